// File: rtl/my_pkg.sv
// Purpose: shared types and constants for the RISC-V Lite fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a. Exports fetch_state_t, ifid_t, NOP_INSTR and a PC increment helper.
package my_pkg;

  // Fetch FSM: nothing pending, one SRAM read in flight, or one word parked in the hold buffer.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    INFLIGHT = 2'd1,
    HELD     = 2'd2
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  // 32-bit modulo increment; wraps 32'hFFFF_FFFC to 0 silently.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Purpose: bundles the fetch stage's control, SRAM and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: stall/redirect flow into the stage; master = fetch stage, slave = its environment.
interface if_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_cs_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        misalign;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_cs_n, imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, misalign
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_cs_n, imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, misalign
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// Purpose: one-entry capture/release register parking an SRAM word that arrives during a stall.
// Latency: captured word visible the cycle after capture.
// Backpressure: none; clr wins over capture. Ports: clk, rst_n, clr, capture, cap_pc/cap_instr in; hold_v/hold_pc/hold_instr out.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        capture,
  input  logic [31:0] cap_pc,
  input  logic [31:0] cap_instr,
  output logic        hold_v,
  output logic [31:0] hold_pc,
  output logic [31:0] hold_instr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v     <= 1'b0;
      hold_pc    <= 32'd0;
      hold_instr <= 32'd0;
    end else if (clr) begin
      hold_v <= 1'b0;
    end else if (capture) begin
      hold_v     <= 1'b1;
      hold_pc    <= cap_pc;
      hold_instr <= cap_instr;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Purpose: instruction fetch; owns PC, drives a 1-cycle synchronous SRAM, loads the IF/ID register.
// Latency: fetch issued in cycle N appears in IF/ID in cycle N+2; redirect target valid at R+3.
// Backpressure: stall freezes PC and IF/ID, parking any in-flight word; redirect squashes everything.
// Ports: clk, rst_n (sync, active-low), bus (if_stage_if.master: stall/redirect in, SRAM, IF/ID, misalign out).
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = my_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
);
  import my_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc;
  ifid_t        ifid_q;
  logic         misalign_q;

  logic         req_v;
  logic         do_run;
  logic         do_capture;
  logic         do_clear;

  logic         hold_v;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_instr;

  logic         avail_v;
  logic [31:0]  avail_pc;
  logic [31:0]  avail_instr;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      state_d = EMPTY;
    end else if (bus.stall) begin
      if (state_q == INFLIGHT) state_d = HELD;
    end else begin
      // Every run cycle issues a fetch, so one is always in flight afterwards.
      state_d = INFLIGHT;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_v      = (state_q == INFLIGHT);
    do_run     = !bus.redirect && !bus.stall;
    // The SRAM word only exists this cycle, so a stall must park it now.
    do_capture = !bus.redirect && bus.stall && req_v;
    do_clear   = bus.redirect || do_run;
  end

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (do_clear),
    .capture    (do_capture),
    .cap_pc     (req_pc),
    .cap_instr  (bus.imem_rdata),
    .hold_v     (hold_v),
    .hold_pc    (hold_pc),
    .hold_instr (hold_instr)
  );

  // Hold entry is always older than a fresh SRAM word, so it takes precedence.
  always_comb begin
    avail_v     = 1'b0;
    avail_pc    = req_pc;
    avail_instr = bus.imem_rdata;
    if (hold_v) begin
      avail_v     = 1'b1;
      avail_pc    = hold_pc;
      avail_instr = hold_instr;
    end else if (req_v) begin
      avail_v = 1'b1;
    end
  end

  // ---------------- PC, request tag, IF/ID, misalign ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= PC_RESET;
      req_pc       <= 32'd0;
      ifid_q.valid <= 1'b0;
      ifid_q.pc    <= 32'd0;
      ifid_q.pc4   <= 32'd4;
      ifid_q.instr <= NOP_INSTR;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect) begin
        pc_q         <= {bus.redirect_pc[31:2], 2'b00};
        ifid_q.valid <= 1'b0;
        ifid_q.instr <= NOP_INSTR;
      end else if (do_run) begin
        pc_q   <= pc_plus4(pc_q);
        req_pc <= pc_q;
        if (avail_v) begin
          ifid_q.valid <= 1'b1;
          ifid_q.pc    <= avail_pc;
          ifid_q.pc4   <= pc_plus4(avail_pc);
          ifid_q.instr <= avail_instr;
        end else begin
          // Bubble keeps the last pc/pc4 so downstream never sees a bogus PC.
          ifid_q.valid <= 1'b0;
          ifid_q.instr <= NOP_INSTR;
        end
      end
    end
  end

  assign bus.imem_cs_n  = !rst_n || bus.stall || bus.redirect;
  assign bus.imem_addr  = pc_q;
  assign bus.ifid_valid = ifid_q.valid;
  assign bus.ifid_pc    = ifid_q.pc;
  assign bus.ifid_pc4   = ifid_q.pc4;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Purpose: self-checking bench for if_stage; queue-based fetch model plus directed literal checks.
// Latency: model expects fetched words two cycles after issue.
// Backpressure: exercises stall, redirect, stall+redirect, misaligned redirect, PC wrap and mid-hold reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  if_stage_if bus ();

  if_stage #(.PC_RESET(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM word k holds 32'h1000_0000 + k.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    if (!bus.imem_cs_n) bus.imem_rdata <= word_at(bus.imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] q[$];
  logic [31:0] m_next;
  logic        m_ok = 1'b0;
  logic        e_valid, e_mis;
  logic [31:0] e_pc, e_pc4, e_instr;

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("m_valid", {31'd0, bus.ifid_valid}, {31'd0, e_valid});
        chk("m_instr", bus.ifid_instr, e_instr);
        chk("m_pc",    bus.ifid_pc, e_pc);
        chk("m_pc4",   bus.ifid_pc4, e_pc4);
        chk("m_misalign", {31'd0, bus.misalign}, {31'd0, e_mis});
        chk("m_cs_n", {31'd0, bus.imem_cs_n},
            {31'd0, !(rst_n && !bus.stall && !bus.redirect)});
        if (rst_n && !bus.stall && !bus.redirect)
          chk("m_addr", bus.imem_addr, m_next);
      end
      // Advance the model with the inputs the coming edge will sample.
      if (!rst_n) begin
        q.delete();
        m_next  = 32'h0;
        e_valid = 1'b0; e_pc = 32'h0; e_pc4 = 32'h4; e_instr = NOP; e_mis = 1'b0;
        m_ok    = 1'b1;
      end else if (bus.redirect) begin
        q.delete();
        m_next  = bus.redirect_pc & 32'hFFFF_FFFC;
        e_valid = 1'b0; e_instr = NOP;
        e_mis   = (bus.redirect_pc % 4) != 0;
      end else if (bus.stall) begin
        e_mis = 1'b0;
      end else begin
        e_mis = 1'b0;
        if (q.size() > 0) begin
          e_pc    = q.pop_front();
          e_valid = 1'b1;
          e_pc4   = e_pc + 32'd4;
          e_instr = word_at(e_pc);
        end else begin
          e_valid = 1'b0; e_instr = NOP;
        end
        q.push_back(m_next);
        m_next = m_next + 32'd4;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst_n           = r;
    bus.stall       = s;
    bus.redirect    = d;
    bus.redirect_pc = t;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic v, input logic [31:0] pc, input logic [31:0] instr);
    chk({name, "_valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
    chk({name, "_instr"}, bus.ifid_instr, instr);
    if (v) chk({name, "_pc"}, bus.ifid_pc, pc);
  endtask

  initial begin
    rst_n = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    lit("reset", 1'b0, 32'h0, NOP);
    chk("reset_pc", bus.ifid_pc, 32'h0);
    chk("reset_pc4", bus.ifid_pc4, 32'h4);
    chk("reset_cs_n", {31'd0, bus.imem_cs_n}, 32'd1);

    // Release: cycles 2..5 show PCs 0,4,8,C.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0);
      lit("run", 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k));
    end

    // Three-cycle stall while a fetch is in flight.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0);
      lit("stall_frozen", 1'b1, 32'hC, 32'h1000_0003);
      chk("stall_cs_n", {31'd0, bus.imem_cs_n}, 32'd1);
    end
    cyc(1, 0, 0, 0);
    lit("after_stall", 1'b1, 32'h10, 32'h1000_0004);
    cyc(1, 0, 0, 0);
    lit("after_stall2", 1'b1, 32'h14, 32'h1000_0005);

    // Plain redirect to 0x100.
    cyc(1, 0, 1, 32'h100);
    lit("redir_b1", 1'b0, 32'h0, NOP);
    cyc(1, 0, 0, 0);
    lit("redir_b2", 1'b0, 32'h0, NOP);
    cyc(1, 0, 0, 0);
    lit("redir_tgt", 1'b1, 32'h100, 32'h1000_0040);
    chk("redir_pc4", bus.ifid_pc4, 32'h104);
    cyc(1, 0, 0, 0);
    lit("redir_next", 1'b1, 32'h104, 32'h1000_0041);

    // Enter HELD, then stall and redirect together.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 32'h200);
    lit("sr_b1", 1'b0, 32'h0, NOP);
    cyc(1, 0, 0, 0);
    lit("sr_b2", 1'b0, 32'h0, NOP);
    cyc(1, 0, 0, 0);
    lit("sr_tgt", 1'b1, 32'h200, 32'h1000_0080);
    cyc(1, 0, 0, 0);
    lit("sr_next", 1'b1, 32'h204, 32'h1000_0081);

    // Misaligned redirect.
    cyc(1, 0, 1, 32'h102);
    chk("mis_pulse", {31'd0, bus.misalign}, 32'd1);
    cyc(1, 0, 0, 0);
    chk("mis_clear", {31'd0, bus.misalign}, 32'd0);
    cyc(1, 0, 0, 0);
    lit("mis_tgt", 1'b1, 32'h100, 32'h1000_0040);

    // PC wrap at the top of the address space.
    cyc(1, 0, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    lit("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);
    cyc(1, 0, 0, 0);
    lit("wrap_zero", 1'b1, 32'h0, 32'h1000_0000);

    // Reset for one cycle while HELD.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    lit("rst_held", 1'b0, 32'h0, NOP);
    chk("rst_held_pc", bus.ifid_pc, 32'h0);
    chk("rst_held_pc4", bus.ifid_pc4, 32'h4);
    cyc(1, 0, 0, 0);
    lit("rst_c1", 1'b0, 32'h0, NOP);
    cyc(1, 0, 0, 0);
    lit("rst_c2", 1'b1, 32'h0, 32'h1000_0000);
    cyc(1, 0, 0, 0);
    lit("rst_c3", 1'b1, 32'h4, 32'h1000_0001);
    cyc(1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V Lite pipeline, directly upstream of the decode/control unit. Owns the PC, drives a single-cycle-latency synchronous instruction SRAM, and loads the IF/ID pipeline register whose `ifid_instr[6:0]` feeds the control unit's `opcode` input. Handles stalls from the hazard unit with a one-entry hold buffer so no in-flight fetch is lost. Handles taken branch/jump redirects by squashing wrong-path fetches.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble instruction.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall` in 1: hazard unit; holds PC and IF/ID.
- `redirect` in 1: taken branch/jump resolved downstream.
- `redirect_pc` in 32: target byte address.
- `imem_cs_n` out 1: SRAM chip select, active-low.
- `imem_addr` out 32: SRAM byte address (= `pc_q`).
- `imem_rdata` in 32: SRAM data, valid the cycle after `imem_cs_n`=0.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_pc` out 32: PC of `ifid_instr`.
- `ifid_pc4` out 32: `ifid_pc`+4, for JAL/JALR link.
- `ifid_instr` out 32: instruction to decode; `[6:0]` is the control unit's opcode.
- `misalign` out 1: registered pulse; last accepted redirect target had `[1:0]`≠0.

## Operation
- Internal state: `pc_q`; in-flight request flag `req_v` plus `req_pc`; hold buffer `hold_v`, `hold_pc`, `hold_instr`; IF/ID register.
- FSM `fetch_state_t`:
  - EMPTY: no request in flight, no hold.
  - INFLIGHT: `req_v`=1.
  - HELD: `hold_v`=1.
- Available instruction `avail`: the hold buffer if `hold_v`; else `imem_rdata`/`req_pc` if `req_v`; else none.
- Per-cycle priority is reset > redirect > stall > run.
- Redirect:
  - `imem_cs_n`=1.
  - `pc_q` <= `redirect_pc & ~3`.
  - `misalign` <= `|redirect_pc[1:0]`.
  - `req_v`, `hold_v` <= 0; IF/ID <= bubble. Next state is EMPTY.
- Stall:
  - `imem_cs_n`=1; `pc_q` and IF/ID hold.
  - If `req_v`: hold buffer <= {`req_pc`, `imem_rdata`}, `hold_v` <= 1, `req_v` <= 0 (INFLIGHT→HELD).
  - If HELD or EMPTY, the state is unchanged.
- Run (no stall, no redirect):
  - `imem_cs_n`=0; `pc_q` <= `pc_q`+4; `req_v` <= 1; `req_pc` <= `pc_q`.
  - IF/ID <= `avail` with `ifid_valid`=1, or a bubble if none.
  - `hold_v` <= 0.
- Bubble: `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`, `ifid_pc`/`ifid_pc4` hold their previous values.
- `ifid_pc4` is registered together with `ifid_pc`. All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- `misalign` clears to 0 on every non-redirect cycle.
- Program order is preserved: the hold entry is always older than any later request, because stall issues no new request.

## Timing
- Reset values, forced while `rst_n`=0 and present the cycle after the reset edge:
  - `pc_q`=`PC_RESET`; `req_v`=`hold_v`=0.
  - `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`, `ifid_pc`=0, `ifid_pc4`=4, `misalign`=0.
- `imem_cs_n` is combinational: 1 whenever `rst_n`=0, `stall`=1 or `redirect`=1.
- After reset release (cycle 0 = first cycle with `rst_n`=1, no stall):
  - Fetch of `PC_RESET` issued in cycle 0.
  - `ifid_valid`=1 with `ifid_pc`=`PC_RESET` from cycle 2.
  - Then one instruction per cycle.
- Redirect sampled at the end of cycle R:
  - Target fetched in R+1; valid in IF/ID from R+3.
  - R+1 and R+2 present bubbles.
- Stall of N cycles: IF/ID is frozen for exactly N cycles. The first cycle after the stall presents the held instruction (if any), with no bubble and no duplicate.
- Stall and redirect in the same cycle: redirect wins.
- Reset asserted mid-stall or mid-redirect discards all state.

## Structure
- Shared package `my_pkg` additions:
  - `fetch_state_t` enum {EMPTY, INFLIGHT, HELD}.
  - `NOP_INSTR` constant.
  - `ifid_t` packed struct {valid, pc, pc4, instr}.
- One sub-module: `fetch_hold_buf`, a one-entry capture/release register with `hold_v`/`hold_pc`/`hold_instr`. The top level holds the PC, FSM and IF/ID register.

## Test plan
- Reset, no stall, SRAM word k = 32'h1000_0000+k: cycles 2..5 show `ifid_pc` 0,4,8,C with matching instructions and `ifid_valid`=1.
- `stall` high for 3 cycles while INFLIGHT: `imem_cs_n`=1 throughout and IF/ID frozen. Next cycle shows the held word. The sequence continues with no loss or duplicate.
- `redirect`=1 with `redirect_pc`=32'h0000_0100: two bubbles (`ifid_instr`=32'h13, valid 0), then `ifid_pc`=0x100. Wrong-path words never appear.
- `redirect` and `stall` both 1 in the same cycle: redirect behaviour exactly as above, and the hold buffer is cleared.
- `redirect_pc`=32'h0000_0102: fetch from 0x100 and `misalign`=1 for exactly one cycle.
- `rst_n`=0 for one cycle during HELD: outputs return to reset values, then the fetch restarts at `PC_RESET` with `ifid_valid` at cycle 2.
